dim_seq: RTL and testbench
==========================

# dim_seq

Key-driven sequencer for the LED dimmer brightness counter. It sits between the two active-low push-button inputs and the up/down brightness counter, and turns key activity into single-cycle `inc`/`dec` step pulses. Behaviour: single-step on press, auto-repeat while held, and a two-key fade-out/fade-in toggle. It reads the counter value back to enforce saturation and to terminate fades.

## Interface
- `CNT_W`, 8: width of brightness counter feedback
- `HOLD_CYC`, 25_000_000: cycles a key must stay low before auto-repeat starts
- `REPEAT_CYC`, 2_500_000: cycles between auto-repeat steps; legal range ≥ 2
- `FADE_CYC`, 100_000: cycles between fade steps; legal range ≥ 2
- `clk  in  1`: single clock, posedge active
- `rst  in  1`: asynchronous reset, active-high
- `key0_n  in  1`: up key, active-low level, already synchronised to `clk`
- `key1_n  in  1`: down key, active-low level, already synchronised to `clk`
- `cnt  in  CNT_W`: current brightness counter value
- `inc  out  1`: one-cycle up-step pulse to counter
- `dec  out  1`: one-cycle down-step pulse to counter
- `off  out  1`: high while in OFF or FADE_OUT
- `busy  out  1`: high during FADE_OUT or FADE_IN

## Operation
- States: IDLE, HOLD_UP, HOLD_DN, FADE_OUT, OFF, FADE_IN, LOCK.
- Press means the key is sampled low while its previous sample was high. Edge detection is internal.
- IDLE, key0 press only: emit `inc`, go to HOLD_UP. Key1 press only: emit `dec`, go to HOLD_DN.
- HOLD_UP/HOLD_DN:
  - Timer runs from the first step. After HOLD_CYC cycles, emit a step, then one every REPEAT_CYC cycles while the key is held.
  - Key release returns to IDLE.
- Combo: both keys low in the same cycle, or the second key pressed during HOLD_x.
  - From IDLE/HOLD_x: latch `cnt` into `level_r` and go to FADE_OUT.
  - From OFF: go to FADE_IN.
- FADE_OUT: emit `dec` every FADE_CYC cycles. When `cnt`==0, go to LOCK, which then exits to OFF.
- FADE_IN: emit `inc` every FADE_CYC cycles. When `cnt`==`level_r`, go to LOCK, which then exits to IDLE.
- OFF: single-key presses are ignored. Only a combo is accepted.
- LOCK: waits until both keys are high, then goes to the pending target (IDLE or OFF). This blocks spurious single presses on combo release.
- Keys are ignored during FADE_OUT/FADE_IN.
- Saturation: `inc` is never emitted when `cnt`==2^CNT_W−1. `dec` is never emitted when `cnt`==0. The step is suppressed, but the timers keep running.
- `level_r` is captured as 0: FADE_IN completes immediately without steps.
- `inc` and `dec` are never high in the same cycle.

## Timing
- Reset values:
  - `inc`=0, `dec`=0, `off`=0, `busy`=0
  - state=IDLE
  - `level_r`=2^CNT_W−1
  - all timers 0
- Press latency: if posedge T is the first to sample the key low, `inc`/`dec` is high for exactly the cycle after posedge T+1.
- Repeat: with the first step at cycle S, further steps occur at S+HOLD_CYC, S+HOLD_CYC+REPEAT_CYC, and so on.
- Fade: the first step is FADE_CYC cycles after entering the fade state, then one every FADE_CYC cycles.
- The minimum spacing of 2 cycles guarantees `cnt` reflects the previous step before the next saturation or termination check.
- Release in the same cycle as a scheduled repeat step: the step is suppressed.
- Reset mid-fade or mid-hold: immediate return to the reset values above. The counter is reset independently.

## Configuration
- `DIM_SEQ_AUTOREPEAT_EN` defined: HOLD/repeat behaviour as above.
- Not defined:
  - A held key produces only the initial step.
  - HOLD_x just waits for release; the HOLD_CYC and REPEAT_CYC parameters are unused.
  - The combo and fade paths are unchanged.

## Structure
- Package `dim_pkg`:
  - state enum `dim_state_t`
  - default constants for HOLD_CYC, REPEAT_CYC, FADE_CYC
  - `DIM_CNT_W`
- Sub-module `dim_tick`:
  - loadable down-counter with `start`/`tick` ports
  - asynchronous active-high reset
  - instantiated once and shared by the hold, repeat and fade intervals

## Test plan
Bench parameters: HOLD_CYC=10, REPEAT_CYC=4, FADE_CYC=3, CNT_W=8. The bench instantiates `dim_seq` together with the up/down counter.

- Key0 low 2 cycles then high, `cnt`=5 → exactly one `inc` one cycle after the press sample; `cnt`=6; no further pulses.
- Key0 held 30 cycles from `cnt`=0 → `inc` at S, S+10, S+14, S+18, S+22, S+26, S+30 (the last only if still held) → `cnt` ends at 6 or 7 per release cycle. Without `DIM_SEQ_AUTOREPEAT_EN` → `cnt`=1.
- `cnt`=255, key0 held 40 cycles → zero `inc` pulses. `cnt`=0 with key1 press → zero `dec` pulses.
- `cnt`=4, both keys low same cycle, then released → `off`=1, `busy`=1; `dec` every 3 cycles; `cnt` reaches 0 after 4 pulses; then OFF with `busy`=0.
- From OFF: key0 alone → no pulse. Combo → `inc` every 3 cycles until `cnt`=4. Then IDLE once both keys are released; `off`=0.
- `rst` asserted mid-FADE_OUT → `inc`/`dec`/`off`/`busy` go 0 asynchronously. After release, state=IDLE and a key0 press gives one `inc`.

Source files
------------

// File: rtl/dim_seq_pkg.sv
// dim_pkg: shared state encoding and default timing constants for the dimmer key sequencer
package dim_pkg;
  typedef enum logic [2:0] {IDLE, HOLD_UP, HOLD_DN, FADE_OUT, OFF, FADE_IN, LOCK} dim_state_t;
  localparam int DIM_CNT_W = 8;
  localparam int DIM_HOLD_CYC = 25_000_000;
  localparam int DIM_REPEAT_CYC = 2_500_000;
  localparam int DIM_FADE_CYC = 100_000;
endpackage

// File: rtl/dim_seq_if.sv
// dim_seq_if: key inputs, counter feedback and step/status outputs of the dimmer sequencer
interface dim_seq_if import dim_pkg::*; #(
  parameter int CNT_W = DIM_CNT_W
) ();
  logic key0_n;
  logic key1_n;
  logic [CNT_W-1:0] cnt;
  logic inc;
  logic dec;
  logic off;
  logic busy;
  modport master(input key0_n, key1_n, cnt, output inc, dec, off, busy);
  modport slave(output key0_n, key1_n, cnt, input inc, dec, off, busy);
endinterface

// File: rtl/dim_seq_tick.sv
// dim_tick: loadable down-counter; tick is high in the cycle before the loaded interval elapses
module dim_tick import dim_pkg::*; #(
  parameter int W = 8
) (
  input logic clk,
  input logic rst,
  input logic start,
  input logic [W-1:0] load,
  output logic tick
);
  logic [W-1:0] c;
  // reload on start, otherwise count down and park at zero
  always_ff @(posedge clk or posedge rst)
    if (rst) c <= '0;
    else if (start) c <= load;
    else if (c != '0) c <= c - 1'b1;
  assign tick = c == W'(1);
endmodule

// File: rtl/dim_seq.sv
// dim_seq: key-driven step/fade sequencer for the LED dimmer; auto-repeat enabled by DIM_SEQ_AUTOREPEAT_EN
module dim_seq import dim_pkg::*; #(
  parameter int CNT_W = DIM_CNT_W,
  parameter int HOLD_CYC = DIM_HOLD_CYC,
  parameter int REPEAT_CYC = DIM_REPEAT_CYC,
  parameter int FADE_CYC = DIM_FADE_CYC
) (
  input logic clk,
  input logic rst,
  dim_seq_if.master bus
);
  localparam int MX = HOLD_CYC > REPEAT_CYC ? (HOLD_CYC > FADE_CYC ? HOLD_CYC : FADE_CYC)
                                            : (REPEAT_CYC > FADE_CYC ? REPEAT_CYC : FADE_CYC);
  localparam int TW = $clog2(MX + 1);
  dim_state_t state, nxt, tgt, tgt_n;
  logic [1:0] k_r, p_r, p;
  logic [CNT_W-1:0] level_r;
  logic [TW-1:0] load;
  logic start, tick, up, dn, cap, combo, at_max, at_zero;
  assign p = p_r & ~k_r;
  assign combo = ~|k_r && |p;
  assign at_max = &bus.cnt;
  assign at_zero = ~|bus.cnt;
  assign bus.off = state == OFF || state == FADE_OUT;
  assign bus.busy = state == FADE_OUT || state == FADE_IN;
  dim_tick #(.W(TW)) u_tick (.clk(clk), .rst(rst), .start(start), .load(load), .tick(tick));
  // next state, step requests and shared-timer reloads
  always_comb begin
    nxt = state;
    tgt_n = tgt;
    up = 1'b0;
    dn = 1'b0;
    cap = 1'b0;
    start = 1'b0;
    load = TW'(FADE_CYC);
    case (state)
      IDLE, HOLD_UP, HOLD_DN, OFF:
        if (combo) begin
          nxt = state == OFF ? FADE_IN : FADE_OUT;
          cap = state != OFF;
          start = 1'b1;
        end else if (state == IDLE && p[0]) begin
          nxt = HOLD_UP;
          up = 1'b1;
          start = 1'b1;
          load = TW'(HOLD_CYC);
        end else if (state == IDLE && p[1]) begin
          nxt = HOLD_DN;
          dn = 1'b1;
          start = 1'b1;
          load = TW'(HOLD_CYC);
        end else if ((state == HOLD_UP && k_r[0]) || (state == HOLD_DN && k_r[1])) nxt = IDLE;
`ifdef DIM_SEQ_AUTOREPEAT_EN
        else if ((state == HOLD_UP || state == HOLD_DN) && tick) begin
          up = state == HOLD_UP;
          dn = state == HOLD_DN;
          start = 1'b1;
          load = TW'(REPEAT_CYC);
        end
`endif
      FADE_OUT:
        if (at_zero) begin
          nxt = LOCK;
          tgt_n = OFF;
        end else if (tick) begin
          dn = 1'b1;
          start = 1'b1;
        end
      FADE_IN:
        if (bus.cnt == level_r) begin
          nxt = LOCK;
          tgt_n = IDLE;
        end else if (tick) begin
          up = 1'b1;
          start = 1'b1;
        end
      LOCK: nxt = &k_r ? tgt : LOCK;
      default: nxt = IDLE;
    endcase
  end
  // state, key edge history, fade level and saturated step pulses
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      tgt <= IDLE;
      level_r <= '1;
      k_r <= 2'b11;
      p_r <= 2'b11;
      bus.inc <= 1'b0;
      bus.dec <= 1'b0;
    end else begin
      state <= nxt;
      tgt <= tgt_n;
      if (cap) level_r <= bus.cnt;
      k_r <= {bus.key1_n, bus.key0_n};
      p_r <= k_r;
      bus.inc <= up && !at_max;
      bus.dec <= dn && !at_zero;
    end
endmodule

// File: tb/tb_dim_seq.sv
// tb_dim_seq: directed self-checking bench for dim_seq driving a behavioural up/down counter
module tb_dim_seq;
`ifdef DIM_SEQ_AUTOREPEAT_EN
  localparam logic [31:0] EXP_REP = 32'h0888_8802;
  localparam logic [31:0] EXP_REP_CNT = 32'd6;
`else
  localparam logic [31:0] EXP_REP = 32'h0000_0002;
  localparam logic [31:0] EXP_REP_CNT = 32'd1;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ld = 1'b0;
  logic [7:0] ld_v = '0;
  logic [7:0] cnt_q = '0;
  logic [31:0] mask;
  int tests = 0, fails = 0, n_inc = 0, n_dec = 0, n_both = 0, base = 0;
  dim_seq_if #(.CNT_W(8)) bus ();
  dim_seq #(.CNT_W(8), .HOLD_CYC(10), .REPEAT_CYC(4), .FADE_CYC(3)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign bus.cnt = cnt_q;
  // brightness counter plus pulse tallies
  always @(posedge clk) begin
    cnt_q <= ld ? ld_v : bus.inc ? cnt_q + 8'd1 : bus.dec ? cnt_q - 8'd1 : cnt_q;
    if (bus.inc) n_inc <= n_inc + 1;
    if (bus.dec) n_dec <= n_dec + 1;
    if (bus.inc && bus.dec) n_both <= n_both + 1;
  end
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic set_cnt(input logic [7:0] v);
    ld = 1'b1;
    ld_v = v;
    step(1);
    ld = 1'b0;
  endtask
  initial begin
    bus.key0_n = 1'b1;
    bus.key1_n = 1'b1;
    step(2);
    chk("rst_inc", bus.inc, 0);
    chk("rst_dec", bus.dec, 0);
    chk("rst_off", bus.off, 0);
    chk("rst_busy", bus.busy, 0);
    rst = 1'b0;
    step(2);
    set_cnt(5);
    base = n_inc;
    bus.key0_n = 1'b0;
    step(1);
    chk("press_early", bus.inc, 0);
    step(1);
    chk("press_lat", bus.inc, 1);
    bus.key0_n = 1'b1;
    step(1);
    chk("press_single", bus.inc, 0);
    step(3);
    chk("press_cnt", cnt_q, 6);
    chk("press_n", n_inc - base, 1);
    set_cnt(0);
    mask = '0;
    bus.key0_n = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      mask[i] = bus.inc;
    end
    bus.key0_n = 1'b1;
    step(4);
    chk("rep_mask", mask, EXP_REP);
    chk("rep_cnt", cnt_q, EXP_REP_CNT);
    set_cnt(255);
    base = n_inc;
    bus.key0_n = 1'b0;
    step(40);
    bus.key0_n = 1'b1;
    step(4);
    chk("sat_inc_n", n_inc - base, 0);
    chk("sat_cnt_max", cnt_q, 255);
    set_cnt(0);
    base = n_dec;
    bus.key1_n = 1'b0;
    step(2);
    bus.key1_n = 1'b1;
    step(4);
    chk("sat_dec_n", n_dec - base, 0);
    chk("sat_cnt_zero", cnt_q, 0);
    set_cnt(4);
    mask = '0;
    bus.key0_n = 1'b0;
    bus.key1_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      mask[i] = bus.dec;
      if (i == 1) begin
        chk("fo_off", bus.off, 1);
        chk("fo_busy", bus.busy, 1);
        bus.key0_n = 1'b1;
        bus.key1_n = 1'b1;
      end
    end
    chk("fo_mask", mask, 32'h0000_2490);
    chk("fo_cnt", cnt_q, 0);
    chk("off_off", bus.off, 1);
    chk("off_busy", bus.busy, 0);
    base = n_inc;
    bus.key0_n = 1'b0;
    step(2);
    bus.key0_n = 1'b1;
    step(3);
    chk("off_single_n", n_inc - base, 0);
    chk("off_stays", bus.off, 1);
    mask = '0;
    bus.key0_n = 1'b0;
    bus.key1_n = 1'b0;
    for (int i = 0; i < 21; i++) begin
      step(1);
      mask[i] = bus.inc;
      if (i == 1) begin
        chk("fi_busy", bus.busy, 1);
        chk("fi_off", bus.off, 0);
      end
    end
    chk("fi_mask", mask, 32'h0000_2490);
    chk("fi_cnt", cnt_q, 4);
    chk("lock_busy", bus.busy, 0);
    bus.key0_n = 1'b1;
    bus.key1_n = 1'b1;
    step(3);
    chk("idle_off", bus.off, 0);
    chk("idle_busy", bus.busy, 0);
    bus.key1_n = 1'b0;
    step(2);
    bus.key1_n = 1'b1;
    step(3);
    chk("idle_dec_cnt", cnt_q, 3);
    bus.key0_n = 1'b0;
    bus.key1_n = 1'b0;
    step(2);
    bus.key0_n = 1'b1;
    bus.key1_n = 1'b1;
    step(4);
    chk("pre_rst_busy", bus.busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_inc", bus.inc, 0);
    chk("arst_dec", bus.dec, 0);
    chk("arst_off", bus.off, 0);
    chk("arst_busy", bus.busy, 0);
    step(1);
    rst = 1'b0;
    step(1);
    set_cnt(7);
    base = n_inc;
    bus.key0_n = 1'b0;
    step(2);
    bus.key0_n = 1'b1;
    step(4);
    chk("post_rst_cnt", cnt_q, 8);
    chk("post_rst_n", n_inc - base, 1);
    chk("never_both", n_both, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
